// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared definitions for the sprite collision sweep controller:
//   - sweep_state_t      : FSM state encoding of the sweep controller
//   - SIZE_PX_*          : square sprite edge length for each 2-bit size code
//   - size_to_px()       : size code -> pixel edge length
//   - DEF_NUM_SPRITES,
//     DEF_END_MOBILE_SPRITE : default sprite-range constants
// -----------------------------------------------------------------------------
package collision_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_MOB,
    LATCH_MOB,
    FETCH_CMP,
    EVAL,
    COMMIT
  } sweep_state_t;

  localparam int SIZE_PX_00 = 8;
  localparam int SIZE_PX_01 = 16;
  localparam int SIZE_PX_10 = 32;
  localparam int SIZE_PX_11 = 64;

  localparam int DEF_NUM_SPRITES       = 32;
  localparam int DEF_END_MOBILE_SPRITE = 14;

  function automatic logic [6:0] size_to_px(input logic [1:0] code);
    logic [6:0] px;
    case (code)
      2'b00:   px = 7'(SIZE_PX_00);
      2'b01:   px = 7'(SIZE_PX_01);
      2'b10:   px = 7'(SIZE_PX_10);
      default: px = 7'(SIZE_PX_11);
    endcase
    return px;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
// Combinational strict axis-aligned bounding-box overlap test between two
// square sprites. Touching edges do not count as overlap. Sums are formed one
// bit wider than the coordinates so a sprite near the right/bottom edge of the
// coordinate space never wraps around.
// Ports:
//   i_xa, i_ya, i_size_a : position and size code of sprite A
//   i_xb, i_yb, i_size_b : position and size code of sprite B
//   o_overlap            : 1 when the two boxes strictly intersect
// -----------------------------------------------------------------------------
module aabb_overlap
  import collision_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] i_xa,
  input  logic [COORD_W-1:0] i_ya,
  input  logic [1:0]         i_size_a,
  input  logic [COORD_W-1:0] i_xb,
  input  logic [COORD_W-1:0] i_yb,
  input  logic [1:0]         i_size_b,
  output logic               o_overlap
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0] w_xa, w_ya, w_xb, w_yb, w_wa, w_wb;
  logic [EW-1:0] w_xa_end, w_ya_end, w_xb_end, w_yb_end;

  assign w_xa = {1'b0, i_xa};
  assign w_ya = {1'b0, i_ya};
  assign w_xb = {1'b0, i_xb};
  assign w_yb = {1'b0, i_yb};
  assign w_wa = EW'(size_to_px(i_size_a));
  assign w_wb = EW'(size_to_px(i_size_b));

  assign w_xa_end = w_xa + w_wa;
  assign w_ya_end = w_ya + w_wa;
  assign w_xb_end = w_xb + w_wb;
  assign w_yb_end = w_yb + w_wb;

  assign o_overlap = (w_xa < w_xb_end) && (w_xb < w_xa_end) &&
                     (w_ya < w_yb_end) && (w_yb < w_ya_end);

endmodule

// File: rtl/collision_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// collision_sweep_ctrl
// Walks every (mobile, comparison) sprite pair once per start pulse, reading
// sprite attributes from an external table with one cycle of read latency,
// and reports one overlap result per pair.
//
// Optional feature macro: COLLISION_SKIP_INACTIVE_EN
//   defined   : a pair with either sprite inactive keeps its EVAL cycle but
//               does not raise enable
//   undefined : activity flags are ignored
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start_sweep                : start pulse, ignored while busy
//   rd_addr                    : attribute table read address
//   rd_x, rd_y, rd_size        : attributes of the sprite addressed last cycle
//   rd_active                  : enable flag of the sprite addressed last cycle
//   enable                     : one pair result is valid this cycle
//   collision_result           : pair overlaps
//   number_of_mobile_sprite    : mobile index of the reported pair
//   number_of_comparison_sprite: comparison index of the reported pair
//   process_finished           : 1 while accumulating, 0 in commit / idle
//   busy                       : sweep in progress
// -----------------------------------------------------------------------------
module collision_sweep_ctrl
  import collision_pkg::*;
#(
  parameter int BITS_TO_SPRITE    = 5,
  parameter int NUM_SPRITES       = DEF_NUM_SPRITES,
  parameter int END_MOBILE_SPRITE = DEF_END_MOBILE_SPRITE,
  parameter int COORD_W           = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_sweep,
  output logic [BITS_TO_SPRITE-1:0] rd_addr,
  input  logic [COORD_W-1:0]        rd_x,
  input  logic [COORD_W-1:0]        rd_y,
  input  logic [1:0]                rd_size,
  input  logic                      rd_active,
  output logic                      enable,
  output logic                      collision_result,
  output logic [BITS_TO_SPRITE-1:0] number_of_mobile_sprite,
  output logic [BITS_TO_SPRITE-1:0] number_of_comparison_sprite,
  output logic                      process_finished,
  output logic                      busy
);

  localparam logic [BITS_TO_SPRITE-1:0] LAST_J = BITS_TO_SPRITE'(NUM_SPRITES - 1);
  localparam logic [BITS_TO_SPRITE-1:0] LAST_I = BITS_TO_SPRITE'(END_MOBILE_SPRITE);

  sweep_state_t r_state, w_state_next;

  logic [BITS_TO_SPRITE-1:0] r_i, w_i_next;
  logic [BITS_TO_SPRITE-1:0] r_j, w_j_next;
  logic [BITS_TO_SPRITE-1:0] w_j_cmp;

  logic [COORD_W-1:0] r_mob_x, r_mob_y;
  logic [1:0]         r_mob_size;
  logic               r_mob_active;

  logic w_overlap;
  logic w_last_j;
  logic w_pair_valid;
  logic w_in_eval;

  // The self pair is skipped inside the same FETCH_CMP cycle, so it costs no
  // time at all: the address jumps straight to the next comparison sprite.
  assign w_j_cmp = (r_j == r_i) ? r_j + 1'b1 : r_j;

  // Last comparison of this mobile. When the mobile is itself the final
  // sprite, the pair just before it is the last real one.
  assign w_last_j = (r_j == LAST_J) ||
                    ((r_i == LAST_J) && ((r_j + 1'b1) == r_i));

  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_j_next     = r_j;
    rd_addr      = '0;
    case (r_state)
      IDLE: begin
        if (start_sweep) begin
          w_state_next = FETCH_MOB;
          w_i_next     = '0;
          w_j_next     = '0;
        end
      end
      FETCH_MOB: begin
        rd_addr      = r_i;
        w_state_next = LATCH_MOB;
      end
      LATCH_MOB: begin
        w_j_next     = '0;
        w_state_next = FETCH_CMP;
      end
      FETCH_CMP: begin
        rd_addr      = w_j_cmp;
        w_j_next     = w_j_cmp;
        w_state_next = EVAL;
      end
      EVAL: begin
        if (w_last_j) begin
          if (r_i == LAST_I) begin
            w_state_next = COMMIT;
          end else begin
            w_i_next     = r_i + 1'b1;
            w_j_next     = '0;
            w_state_next = FETCH_MOB;
          end
        end else begin
          w_j_next     = r_j + 1'b1;
          w_state_next = FETCH_CMP;
        end
      end
      COMMIT: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_mob_x      <= '0;
      r_mob_y      <= '0;
      r_mob_size   <= '0;
      r_mob_active <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_j     <= w_j_next;
      // Mobile attributes arrive one cycle after FETCH_MOB drove the address.
      if (r_state == LATCH_MOB) begin
        r_mob_x      <= rd_x;
        r_mob_y      <= rd_y;
        r_mob_size   <= rd_size;
        r_mob_active <= rd_active;
      end
    end
  end

  aabb_overlap #(
    .COORD_W (COORD_W)
  ) u_aabb_overlap (
    .i_xa      (r_mob_x),
    .i_ya      (r_mob_y),
    .i_size_a  (r_mob_size),
    .i_xb      (rd_x),
    .i_yb      (rd_y),
    .i_size_b  (rd_size),
    .o_overlap (w_overlap)
  );

`ifdef COLLISION_SKIP_INACTIVE_EN
  assign w_pair_valid = r_mob_active & rd_active;
`else
  logic w_unused_active;
  assign w_pair_valid    = 1'b1;
  assign w_unused_active = r_mob_active ^ rd_active;
`endif

  assign w_in_eval = (r_state == EVAL);

  assign enable                      = w_in_eval & w_pair_valid;
  assign collision_result            = w_in_eval & w_pair_valid & w_overlap;
  assign number_of_mobile_sprite     = r_i;
  assign number_of_comparison_sprite = r_j;
  assign busy                        = (r_state != IDLE);
  assign process_finished            = (r_state != IDLE) && (r_state != COMMIT);

endmodule

// File: tb/tb_collision_sweep_ctrl.sv
module tb_collision_sweep_ctrl;

  localparam int NSPR     = 32;
  localparam int LAST_MOB = 14;
  localparam int MOB_COST = 64;   // 2 + 2 * 31 cycles per mobile
  localparam int SWEEP    = 960;  // accept edge to COMMIT

  logic       clk;
  logic       reset;
  logic       start_sweep;
  logic [4:0] rd_addr;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic [1:0] rd_size;
  logic       rd_active;
  logic       enable;
  logic       collision_result;
  logic [4:0] number_of_mobile_sprite;
  logic [4:0] number_of_comparison_sprite;
  logic       process_finished;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Sprite attribute table, read with one cycle of latency.
  logic [9:0] mem_x      [NSPR];
  logic [9:0] mem_y      [NSPR];
  logic [1:0] mem_size   [NSPR];
  logic       mem_active [NSPR];

  typedef struct {
    int cyc;
    int i;
    int j;
    bit res;
  } pair_t;

  pair_t exp_q[$];
  int    exp_total;
  int    last_npulse;
  int    seen_0_20;
  int    obs_0_20;
  int    hits_20;

  collision_sweep_ctrl dut (
    .clk                         (clk),
    .reset                       (reset),
    .start_sweep                 (start_sweep),
    .rd_addr                     (rd_addr),
    .rd_x                        (rd_x),
    .rd_y                        (rd_y),
    .rd_size                     (rd_size),
    .rd_active                   (rd_active),
    .enable                      (enable),
    .collision_result            (collision_result),
    .number_of_mobile_sprite     (number_of_mobile_sprite),
    .number_of_comparison_sprite (number_of_comparison_sprite),
    .process_finished            (process_finished),
    .busy                        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_x      <= mem_x[rd_addr];
    rd_y      <= mem_y[rd_addr];
    rd_size   <= mem_size[rd_addr];
    rd_active <= mem_active[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Square boxes, strict inequality, plain integer arithmetic (never wraps).
  function automatic bit model_overlap(input int xa, input int ya, input int sa,
                                       input int xb, input int yb, input int sb);
    int wa;
    int wb;
    wa = 8 << sa;
    wb = 8 << sb;
    return (xa < xb + wb) && (xb < xa + wa) && (ya < yb + wb) && (yb < ya + wa);
  endfunction

  // Every mobile i costs 64 cycles; its k-th non-self pair is evaluated in
  // cycle 64*i + 3 + 2*k counted from the start-accept edge.
  function automatic void build_expected();
    int  k;
    bit  keep;
    pair_t p;
    exp_q.delete();
    exp_total = 0;
    for (int i = 0; i <= LAST_MOB; i++) begin
      k = 0;
      for (int j = 0; j < NSPR; j++) begin
        if (j == i) continue;
        keep = 1'b1;
`ifdef COLLISION_SKIP_INACTIVE_EN
        keep = mem_active[i] && mem_active[j];
`endif
        if (keep) begin
          p.cyc = MOB_COST * i + 3 + 2 * k;
          p.i   = i;
          p.j   = j;
          p.res = model_overlap(int'(mem_x[i]), int'(mem_y[i]), int'(mem_size[i]),
                                int'(mem_x[j]), int'(mem_y[j]), int'(mem_size[j]));
          exp_q.push_back(p);
          exp_total++;
        end
        k++;
      end
    end
  endfunction

  task automatic fill_random(input int lo, input int hi, input bit rand_active);
    for (int s = 0; s < NSPR; s++) begin
      mem_x[s]      = 10'($urandom_range(hi, lo));
      mem_y[s]      = 10'($urandom_range(hi, lo));
      mem_size[s]   = 2'($urandom_range(3, 0));
      mem_active[s] = rand_active ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_collision_result"}, collision_result, 0);
    check({tag, "_process_finished"}, process_finished, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_mobile_idx"}, number_of_mobile_sprite, 0);
    check({tag, "_cmp_idx"}, number_of_comparison_sprite, 0);
  endtask

  // One sweep, sampled on falling edges. repulse_at / reset_at give the cycle
  // (from accept) at which a second start or a reset is driven; -1 disables.
  task automatic run_sweep(input string name, input int repulse_at, input int reset_at);
    int    npulse;
    pair_t p;
    build_expected();
    npulse    = 0;
    seen_0_20 = 0;
    obs_0_20  = 0;
    hits_20   = 0;
    @(negedge clk);
    start_sweep = 1'b1;
    @(negedge clk);
    start_sweep = 1'b0;
    for (int c = 0; c <= SWEEP + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c == SWEEP + 1) begin
        check({name, "_busy_after_commit"}, busy, 0);
        check({name, "_pf_idle"}, process_finished, 0);
        break;
      end
      if (enable === 1'b1) begin
        npulse++;
        if (number_of_mobile_sprite == 0 && number_of_comparison_sprite == 20) begin
          seen_0_20 = 1;
          obs_0_20  = int'(collision_result);
        end
        if (number_of_mobile_sprite == 20 || number_of_comparison_sprite == 20) hits_20++;
        if (exp_q.size() == 0) begin
          check({name, "_unexpected_pulse_cycle"}, c, 32'hFFFF_FFFF);
        end else begin
          p = exp_q.pop_front();
          check({name, "_pulse_cycle"}, c, p.cyc);
          check({name, "_pulse_i"}, number_of_mobile_sprite, p.i);
          check({name, "_pulse_j"}, number_of_comparison_sprite, p.j);
          check({name, "_pulse_result"}, collision_result, p.res);
        end
      end
      if (c == 0 || c == SWEEP - 1 || c == SWEEP || c == repulse_at + 1) begin
        check({name, "_process_finished"}, process_finished, (c < SWEEP) ? 1 : 0);
        check({name, "_busy"}, busy, 1);
      end
      start_sweep = (c == repulse_at);
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_all_zero({name, "_midreset"});
        reset = 1'b0;
        last_npulse = npulse;
        return;
      end
    end
    start_sweep = 1'b0;
    last_npulse = npulse;
    check({name, "_pulse_count"}, npulse, exp_total);
    check({name, "_leftover_pairs"}, exp_q.size(), 0);
  endtask

  initial begin
    reset       = 1'b1;
    start_sweep = 1'b0;
    fill_random(0, 255, 1'b0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Overlapping pair (0,20).
    fill_random(0, 255, 1'b0);
    mem_x[0] = 10'd100; mem_y[0] = 10'd100; mem_size[0] = 2'b00;
    mem_x[20] = 10'd104; mem_y[20] = 10'd104; mem_size[20] = 2'b00;
    run_sweep("overlap", -1, -1);
    check("overlap_seen_0_20", seen_0_20, 1);
    check("overlap_result_0_20", obs_0_20, 1);
    check("overlap_count_465", last_npulse, 465);

    // Edge-touching pair (0,20).
    mem_x[20] = 10'd108; mem_y[20] = 10'd100;
    run_sweep("touch", -1, -1);
    check("touch_seen_0_20", seen_0_20, 1);
    check("touch_result_0_20", obs_0_20, 0);

    // Sprites crowded against the far corner: sums must not wrap.
    fill_random(950, 1023, 1'b0);
    run_sweep("corner", -1, -1);
    check("corner_count_465", last_npulse, 465);

    // Random attributes including random activity flags.
    fill_random(0, 300, 1'b1);
    run_sweep("random_active", -1, -1);

    // Second start while busy must be ignored.
    fill_random(0, 200, 1'b0);
    run_sweep("repulse", 300, -1);
    check("repulse_count_465", last_npulse, 465);

    // Reset mid-sweep, then a clean restart from mobile 0.
    run_sweep("abort", -1, 500);
    repeat (2) @(negedge clk);
    check_all_zero("after_abort");
    run_sweep("restart", -1, -1);
    check("restart_count_465", last_npulse, 465);

    // Sprite 20 inactive while overlapping mobile 0.
    fill_random(0, 255, 1'b0);
    mem_x[0] = 10'd100; mem_y[0] = 10'd100; mem_size[0] = 2'b00;
    mem_x[20] = 10'd104; mem_y[20] = 10'd104; mem_size[20] = 2'b00;
    mem_active[20] = 1'b0;
    run_sweep("inactive20", -1, -1);
`ifdef COLLISION_SKIP_INACTIVE_EN
    check("inactive20_hits", hits_20, 0);
    check("inactive20_count", last_npulse, 465 - 15);
`else
    check("inactive20_seen_0_20", seen_0_20, 1);
    check("inactive20_result_0_20", obs_0_20, 1);
    check("inactive20_count_465", last_npulse, 465);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_sweep_ctrl.md
COLLISION_SWEEP_CTRL -- requirements
Module: collision_sweep_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk` (input, 1, rising-edge clock), then `reset` (input, 1).
REQ-002 Parameters SHALL be:
- `BITS_TO_SPRITE`, default 5, sprite index width.
- `NUM_SPRITES`, default 32, total sprites.
- `END_MOBILE_SPRITE`, default 14, last mobile index; mobiles are 0..END_MOBILE_SPRITE.
- `COORD_W`, default 10, coordinate width.
REQ-003 Ports SHALL be:
- `start_sweep` input 1: start pulse (frame/vblank).
- `rd_addr` output BITS_TO_SPRITE: sprite attribute read address.
- `rd_x` input COORD_W: X of the sprite at `rd_addr`.
- `rd_y` input COORD_W: Y of the sprite at `rd_addr`.
- `rd_size` input 2: size code of the sprite at `rd_addr`.
- `rd_active` input 1: sprite enabled.
- `enable` output 1: pair result valid.
- `collision_result` output 1: pair overlaps.
- `number_of_mobile_sprite` output BITS_TO_SPRITE: mobile index of the pair.
- `number_of_comparison_sprite` output BITS_TO_SPRITE: comparison index of the pair.
- `process_finished` output 1: 1 = accumulation window, 0 = commit window.
- `busy` output 1: sweep in progress.

Function
REQ-004 Read data (`rd_x`, `rd_y`, `rd_size`, `rd_active`) SHALL be valid exactly 1 cycle after `rd_addr` is driven.
REQ-005 FSM states SHALL be IDLE, FETCH_MOB, LATCH_MOB, FETCH_CMP, EVAL, COMMIT.
REQ-006 Transitions SHALL be:
- IDLE -> FETCH_MOB on `start_sweep`; mobile index i=0, comparison index j=0.
- FETCH_MOB -> LATCH_MOB: `rd_addr`=i.
- LATCH_MOB -> FETCH_CMP: mobile attributes captured.
- FETCH_CMP -> EVAL: `rd_addr`=j.
- EVAL -> FETCH_CMP for the next j.
- EVAL -> FETCH_MOB after j=NUM_SPRITES-1.
- EVAL -> COMMIT after the last j of i=END_MOBILE_SPRITE.
- COMMIT -> IDLE after 1 cycle.
REQ-007 When j==i, the pair SHALL be skipped: j increments in FETCH_CMP with no EVAL cycle and no `enable`. A mobile costs 2 cycles plus 2 per non-self pair.
REQ-008 In EVAL, `enable`=1 for exactly that cycle, and `number_of_mobile_sprite`=i, `number_of_comparison_sprite`=j, `collision_result`=overlap (subject to REQ-015), all registered and stable in the same cycle.
REQ-009 Overlap SHALL be strict AABB: xa<xb+wb AND xb<xa+wa AND ya<yb+wb AND yb<ya+wa.
- Computed at COORD_W+1 bits, no wrap.
- Edge-touching is not a collision.
REQ-010 Size codes SHALL map 00=8, 01=16, 10=32, 11=64 pixels (square).
REQ-011 `process_finished`:
- 1 from the cycle after `start_sweep` is accepted through the last EVAL.
- 0 in COMMIT and IDLE.
REQ-012 `busy`=1 in every state except IDLE. `start_sweep` while busy SHALL be ignored.
REQ-013 Sweep latency, start accept to COMMIT, SHALL be 15*(2+31*2)=960 cycles for default parameters.

Reset
REQ-014 When `reset`=1 at a clock edge, the block SHALL:
- return the FSM to IDLE and clear i and j;
- set `enable`, `collision_result`, `process_finished`, `busy` to 0;
- set `rd_addr` and both sprite indices to 0.
Reset mid-sweep SHALL abandon the sweep with no COMMIT cycle, and the next `start_sweep` restarts at i=0.

Configuration
REQ-015 Macro `COLLISION_SKIP_INACTIVE_EN`:
- Defined: if either sprite has `rd_active`=0, the EVAL cycle still occurs (cycle count unchanged) but `enable` stays 0.
- Undefined: activity is ignored, and inactive sprites are evaluated geometrically like any other.

Structure
REQ-016 Shared package `collision_pkg` SHALL hold:
- the FSM state typedef;
- the size-code-to-pixel constants;
- default sprite-range constants (END_MOBILE_SPRITE=14, NUM_SPRITES=32).
REQ-017 Overlap logic SHALL be a combinational sub-module `aabb_overlap`, one instance.

Verification
REQ-018 Bench SHALL cover:
- Mobile 0 at (100,100) size 00, sprite 20 at (104,104) size 00 -> `enable` with result 1 for pair (0,20).
- Sprite 20 moved to (108,100), edge-touching -> pair (0,20) result 0.
- Full sweep, defaults -> exactly 465 `enable` pulses, `process_finished` low at cycle 960, `busy` falls after COMMIT.
- `start_sweep` re-pulsed at cycle 300 -> ignored, pulse count unchanged.
- `reset` at cycle 500 -> all outputs 0 next cycle; a new start gives 465 pulses again.
- `COLLISION_SKIP_INACTIVE_EN` defined, sprite 20 inactive and overlapping -> no `enable` for any pair with j=20 or i=20; sweep still 960 cycles.
